// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage: word width, instruction
// register field positions and the fetch FSM state encoding.
package cpu_pkg;

    localparam int WORD_W = 16;

    localparam int IR1_HI = 15;
    localparam int IR1_LO = 12;
    localparam int IR2_HI = 11;
    localparam int IR2_LO = 10;
    localparam int IR3_HI = 9;
    localparam int IR3_LO = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_EXEC = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selector: return target wins over a taken branch, which wins
// over the plain increment. All arithmetic wraps modulo 2^16.
module pc_next
    import cpu_pkg::*;
#(
    parameter int OFFSET_BITS = 8
) (
    input  logic [WORD_W-1:0]      i_pc,
    input  logic [OFFSET_BITS-1:0] i_offset,
    input  logic                   i_branchTaken,
    input  logic                   i_doReturn,
    input  logic [WORD_W-1:0]      i_returnAddr,
    output logic [WORD_W-1:0]      o_pcNext
);

    logic [WORD_W-1:0] w_offsetExt;
    logic [WORD_W-1:0] w_pcInc;

    // Sign-extend the branch offset and form pc+1 for both sequential and branch targets
    always_comb begin
        w_offsetExt = {{(WORD_W-OFFSET_BITS){i_offset[OFFSET_BITS-1]}}, i_offset};
        w_pcInc     = i_pc + 16'd1;
    end

    // Pick the target in priority order: return, taken branch, sequential
    always_comb begin
        o_pcNext = w_pcInc;
        if (i_doReturn) begin
            o_pcNext = i_returnAddr;
        end else if (i_branchTaken) begin
            o_pcNext = w_pcInc + w_offsetExt;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word per instruction
// over a req/ack handshake, latches it into IR and advances the PC once
// the datapath reports the instruction finished.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          OFFSET_BITS = 8,
    parameter int          TIMEOUT     = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] ir,
    output logic [3:0]  ir_1,
    output logic [1:0]  ir_2,
    output logic [1:0]  ir_3,
    output logic        ir_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic        do_return,
    input  logic [15:0] return_addr,
    output logic [15:0] pc,
    output logic        imem_err
);

    // The counter holds the number of ack-less cycles already spent in S_REQ;
    // the fetch gives up on the cycle that would make it reach TIMEOUT.
    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    fetch_state_t      r_state;
    fetch_state_t      w_stateNext;
    logic [15:0]       r_pc;
    logic [15:0]       r_ir;
    logic              r_irValid;
    logic              r_imemErr;
    logic [CNT_W-1:0]  r_waitCnt;
    logic [15:0]       w_pcNext;

    pc_next #(
        .OFFSET_BITS (OFFSET_BITS)
    ) u_pcNext (
        .i_pc          (r_pc),
        .i_offset      (r_ir[OFFSET_BITS-1:0]),
        .i_branchTaken (branch_taken),
        .i_doReturn    (do_return),
        .i_returnAddr  (return_addr),
        .o_pcNext      (w_pcNext)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: ack ends a fetch, timeout aborts it, exec_done ends execution
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (fetch_en) begin
                    w_stateNext = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    w_stateNext = S_EXEC;
                end else if (r_waitCnt == LAST_WAIT) begin
                    w_stateNext = S_IDLE;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    w_stateNext = fetch_en ? S_REQ : S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // PC, IR, valid flag, sticky error and wait counter, each only touched in its owning state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= 16'h0000;
            r_irValid <= 1'b0;
            r_imemErr <= 1'b0;
            r_waitCnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_en) begin
                        r_waitCnt <= '0;
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        r_ir      <= imem_data;
                        r_irValid <= 1'b1;
                    end else if (r_waitCnt == LAST_WAIT) begin
                        r_imemErr <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        r_irValid <= 1'b0;
                        r_pc      <= w_pcNext;
                        r_waitCnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Request and address are pure functions of state and PC
    always_comb begin
        imem_req  = (r_state == S_REQ);
        imem_addr = r_pc;
    end

    assign pc       = r_pc;
    assign ir       = r_ir;
    assign ir_valid = r_irValid;
    assign imem_err = r_imemErr;
    assign ir_1     = r_ir[IR1_HI:IR1_LO];
    assign ir_2     = r_ir[IR2_HI:IR2_LO];
    assign ir_3     = r_ir[IR3_HI:IR3_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected IR words and PC values are queued
// when the stimulus is driven and checked when the DUT produces them.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] ir;
    logic [3:0]  ir_1;
    logic [1:0]  ir_2;
    logic [1:0]  ir_3;
    logic        ir_valid;
    logic        exec_done;
    logic        branch_taken;
    logic        do_return;
    logic [15:0] return_addr;
    logic [15:0] pc;
    logic        imem_err;

    int errors = 0;
    int checks = 0;

    logic [15:0] irQ[$];
    logic [15:0] pcQ[$];

    fetch_unit #(
        .RESET_PC    (16'h0000),
        .OFFSET_BITS (8),
        .TIMEOUT     (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_en     (fetch_en),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .ir           (ir),
        .ir_1         (ir_1),
        .ir_2         (ir_2),
        .ir_3         (ir_3),
        .ir_valid     (ir_valid),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .do_return    (do_return),
        .return_addr  (return_addr),
        .pc           (pc),
        .imem_err     (imem_err)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fe, input logic ack, input logic [15:0] data,
                                 input logic done, input logic br, input logic ret,
                                 input logic [15:0] raddr);
        fetch_en     = fe;
        imem_ack     = ack;
        imem_data    = data;
        exec_done    = done;
        branch_taken = br;
        do_return    = ret;
        return_addr  = raddr;
    endtask

    // Wait for a request, hold off the ack for ackDelay cycles, then deliver word
    task automatic fetchWord(input logic [15:0] word, input int ackDelay, input logic [15:0] expAddr);
        logic [15:0] expIr;
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i <= ackDelay; i++) begin
            checkOutput("imem_req_high", {15'd0, imem_req}, 16'd1);
            checkOutput("imem_addr", imem_addr, expAddr);
            if (i == ackDelay) begin
                applyStimulus(fetch_en, 1'b1, word, 1'b0, 1'b0, 1'b0, 16'h0000);
                irQ.push_back(word);
            end
            @(negedge clk);
        end
        applyStimulus(fetch_en, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        expIr = (irQ.size() > 0) ? irQ.pop_front() : 16'hxxxx;
        checkOutput("ir_valid_set", {15'd0, ir_valid}, 16'd1);
        checkOutput("ir_latched", ir, expIr);
        checkOutput("imem_req_low_exec", {15'd0, imem_req}, 16'd0);
    endtask

    // Signal completion of the current instruction and check the resulting PC
    task automatic executeInstr(input logic br, input logic ret, input logic [15:0] raddr,
                                input logic [15:0] expPc, input logic fetchNext);
        logic [15:0] want;
        applyStimulus(fetchNext, 1'b0, 16'h0000, 1'b1, br, ret, raddr);
        pcQ.push_back(expPc);
        @(negedge clk);
        applyStimulus(fetchNext, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        want = (pcQ.size() > 0) ? pcQ.pop_front() : 16'hxxxx;
        checkOutput("pc_after_exec", pc, want);
        checkOutput("ir_valid_clear", {15'd0, ir_valid}, 16'd0);
    endtask

    initial begin
        int reqCycles;

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        checkOutput("rst_pc", pc, 16'h0000);
        checkOutput("rst_ir", ir, 16'h0000);
        checkOutput("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
        checkOutput("rst_imem_req", {15'd0, imem_req}, 16'd0);
        checkOutput("rst_imem_err", {15'd0, imem_err}, 16'd0);
        checkOutput("rst_ir_1", {12'd0, ir_1}, 16'd0);

        // First fetch: ack arrives on the third request cycle
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        fetchWord(16'hF400, 2, 16'h0000);
        checkOutput("ir_1", {12'd0, ir_1}, 16'h000F);
        checkOutput("ir_2", {14'd0, ir_2}, 16'h0001);
        checkOutput("ir_3", {14'd0, ir_3}, 16'h0000);

        // A stray ack while executing must not disturb IR, valid or PC
        applyStimulus(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("hold_ir", ir, 16'hF400);
        checkOutput("hold_valid", {15'd0, ir_valid}, 16'd1);
        checkOutput("hold_pc", pc, 16'h0000);

        // Sequential advance, then return to 0x0010
        executeInstr(1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1);
        fetchWord(16'h7000, 0, 16'h0001);
        executeInstr(1'b0, 1'b1, 16'h0010, 16'h0010, 1'b1);

        // Negative branch offset: 0x10 + 1 - 2
        fetchWord(16'h20FE, 1, 16'h0010);
        executeInstr(1'b1, 1'b0, 16'h0000, 16'h000F, 1'b1);

        // Return beats branch, back to 0x0010
        fetchWord(16'h6000, 0, 16'h000F);
        executeInstr(1'b1, 1'b1, 16'h0010, 16'h0010, 1'b1);

        // Positive branch offset: 0x10 + 1 + 5
        fetchWord(16'h2005, 0, 16'h0010);
        executeInstr(1'b1, 1'b0, 16'h0000, 16'h0016, 1'b1);

        // Return and branch together: return target 0x1234 wins
        fetchWord(16'h30FF, 0, 16'h0016);
        executeInstr(1'b1, 1'b1, 16'h1234, 16'h1234, 1'b1);

        // Timeout at 0x1234; dropping fetch_en does not abort the request
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        reqCycles = 0;
        while (imem_req === 1'b1 && reqCycles < 40) begin
            reqCycles++;
            @(negedge clk);
        end
        checkOutput("timeout_cycles", 16'(reqCycles), 16'd15);
        checkOutput("timeout_err", {15'd0, imem_err}, 16'd1);
        checkOutput("timeout_idle_req", {15'd0, imem_req}, 16'd0);
        checkOutput("timeout_pc", pc, 16'h1234);

        // Execution inputs are ignored while idle; error flag stays set
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hAAAA);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        checkOutput("idle_ignore_pc", pc, 16'h1234);
        checkOutput("err_sticky", {15'd0, imem_err}, 16'd1);

        // Refetch at 0x1234, return to 0xFFFF, then wrap to 0x0000
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        fetchWord(16'h0000, 0, 16'h1234);
        executeInstr(1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        fetchWord(16'h00FE, 0, 16'hFFFF);
        executeInstr(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        fetchWord(16'h5A3C, 0, 16'h0000);
        checkOutput("err_still_sticky", {15'd0, imem_err}, 16'd1);

        // Reset while a fetch at 0x0001 is outstanding, then a late ack
        executeInstr(1'b0, 1'b0, 16'h0000, 16'h0001, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_req", {15'd0, imem_req}, 16'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_pc", pc, 16'h0000);
        checkOutput("midreset_req", {15'd0, imem_req}, 16'd0);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        checkOutput("late_ack_ir", ir, 16'h0000);
        checkOutput("late_ack_valid", {15'd0, ir_valid}, 16'd0);
        checkOutput("late_ack_pc", pc, 16'h0000);
        checkOutput("late_ack_err", {15'd0, imem_err}, 16'd0);
        checkOutput("late_ack_ir_1", {12'd0, ir_1}, 16'd0);
        checkOutput("scoreboard_drained", 16'(irQ.size() + pcQ.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle controller/datapath.
- Holds the 16-bit PC and fetches one instruction word per instruction from instruction memory over a req/ack handshake.
- Latches the word into IR and presents the decoded fields ir_1 = ir[15:12], ir_2 = ir[11:10], ir_3 = ir[9:8] with a valid flag.
- Computes the next PC from the controller's branch/return outcome once execution completes.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- OFFSET_BITS, 8, width of the signed branch offset taken from ir[OFFSET_BITS-1:0].
- TIMEOUT, 15, maximum wait cycles for imem_ack before a fetch error.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- fetch_en  input  1  allows leaving IDLE and starting a fetch
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  16  fetch address, equals pc
- imem_ack  input  1  memory has valid imem_data this cycle
- imem_data  input  16  instruction word from memory
- ir  output  16  latched instruction register
- ir_1  output  4  ir[15:12]
- ir_2  output  2  ir[11:10]
- ir_3  output  2  ir[9:8]
- ir_valid  output  1  ir holds an instruction awaiting execution
- exec_done  input  1  datapath has finished the current instruction
- branch_taken  input  1  conditional branch taken (controller branch AND cc), sampled with exec_done
- do_return  input  1  return instruction (controller muxreturn), sampled with exec_done
- return_addr  input  16  return target (ALU output), used when do_return = 1
- pc  output  16  current program counter
- imem_err  output  1  sticky fetch-timeout flag

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset (asynchronous) values:
  - state = S_IDLE, pc = RESET_PC, ir = 16'h0000
  - ir_valid = 0, imem_req = 0, imem_err = 0, wait counter = 0
- FSM states: S_IDLE, S_REQ, S_EXEC.
- S_IDLE:
  - imem_req = 0, ir_valid = 0.
  - fetch_en = 1 at a clock edge -> S_REQ, wait counter cleared.
- S_REQ:
  - imem_req = 1 (Moore output), imem_addr = pc.
  - imem_ack = 1: ir <= imem_data, ir_valid <= 1, go to S_EXEC. Latency is 1 cycle from ack to ir_valid.
  - No ack: wait counter increments.
  - Counter reaches TIMEOUT with no ack: imem_err <= 1 (sticky until reset), go to S_IDLE, pc unchanged.
- S_EXEC:
  - ir and ir_valid are held stable; imem_req = 0.
  - exec_done = 1: ir_valid <= 0 and pc is updated by priority:
    - do_return = 1 -> pc <= return_addr
    - else branch_taken = 1 -> pc <= pc + 1 + sext(ir[OFFSET_BITS-1:0])
    - else -> pc <= pc + 1
  - Then go to S_REQ if fetch_en = 1, otherwise S_IDLE.
- Arithmetic: all PC arithmetic is modulo 2^16, so 16'hFFFF + 1 wraps to 16'h0000. Offset is two's-complement, sign-extended to 16 bits.
- Ignored inputs:
  - imem_ack outside S_REQ.
  - exec_done, branch_taken, do_return outside S_EXEC.
- do_return and branch_taken both high: return wins.
- fetch_en deassert in S_REQ does not abort an outstanding request; it only blocks the next fetch.
- Reset mid-fetch or mid-exec: immediate return to reset values; a late imem_ack after reset is ignored.
- Decoded fields are continuous slices of ir, so they are 0 after reset.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding: S_IDLE = 2'b00, S_REQ = 2'b01, S_EXEC = 2'b10
  - word width 16
  - IR field bit positions
- One natural sub-module, pc_next: combinational next-PC selector (increment, branch add with sign extension, return mux).
- FSM, wait counter and IR register stay in fetch_unit.

Test Plan:
- Reset, then fetch_en = 1, memory acks after 2 cycles with 16'hF400 -> imem_req high with imem_addr 0 for 3 cycles; ir = 16'hF400, ir_1 = 4'hF, ir_2 = 2'b01, ir_3 = 2'b00, ir_valid = 1; exec_done -> pc = 1.
- pc = 16'h0010, ir = 16'h2_0FE (low byte 8'hFE), exec_done with branch_taken = 1 -> pc = 16'h000F; low byte 8'h05 -> pc = 16'h0016.
- exec_done with do_return = 1, branch_taken = 1, return_addr = 16'h1234 -> pc = 16'h1234.
- pc = 16'hFFFF, exec_done with no branch -> pc = 16'h0000, next imem_addr = 0.
- No imem_ack in S_REQ -> imem_err = 1 after TIMEOUT cycles, state S_IDLE, pc unchanged; flag stays set until reset.
- Assert reset while waiting in S_REQ, then pulse imem_ack -> ir stays 0, ir_valid = 0, pc = RESET_PC.
